// File: rtl/add16u_err_monitor.sv
// -----------------------------------------------------------------------------
// add16u_err_monitor
//
// Streaming error-characterisation stage that sits directly behind a W-bit
// approximate adder. For every accepted sample it forms the exact sum A+B and
// the error magnitude |A+B-O|. Over a window of N samples it accumulates:
//   err_cnt     - samples with nonzero error (error-probability numerator)
//   sum_abs_err - sum of |err|               (mean-absolute-error numerator)
//   sum_sq_err  - sum of err^2               (mean-squared-error numerator)
//   wce         - worst-case |err|, with the operands that first produced it
// All accumulators saturate at all-ones and never wrap. The results are held
// once the window completes.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             pulse: latch n_samples, clear stats, open a window
//   n_samples         window length N (N==0 completes with empty stats)
//   in_valid/in_ready sample handshake; transfer = in_valid & in_ready
//   A, B, O           adder operands and approximate result (O is W+1 bits)
//   busy              window in progress (RUN or DRAIN)
//   done              level; statistics final and stable
//   sample_cnt        samples accepted in this window
//   err_cnt, sum_abs_err, sum_sq_err, wce, wce_A, wce_B  statistics
//
// Timing: a sample accepted on edge t sits in S1 after t, in S2 after t+1,
// and is folded into the statistics on edge t+2. sample_cnt counts at t.
// -----------------------------------------------------------------------------
module add16u_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48,
  parameter int SQ_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W:0]       O,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [SQ_W-1:0]  sum_sq_err,
  output logic [W:0]       wce,
  output logic [W-1:0]     wce_A,
  output logic [W-1:0]     wce_B
);

  localparam int E_W    = W + 1;      // error magnitude width
  localparam int SQP_W  = 2 * W + 2;  // width of err*err

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------- control
  state_t           state_q;
  logic [CNT_W-1:0] n_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] sample_cnt_q;

  // ---------------------------------------------------------------- pipeline
  logic             s1_vld_q;
  logic [E_W-1:0]   s1_err_q;
  logic [W-1:0]     s1_a_q;
  logic [W-1:0]     s1_b_q;

  logic             s2_vld_q;
  logic [E_W-1:0]   s2_err_q;
  logic [SQP_W-1:0] s2_sq_q;
  logic [W-1:0]     s2_a_q;
  logic [W-1:0]     s2_b_q;

  // ---------------------------------------------------------------- stats
  logic [CNT_W-1:0] err_cnt_q;
  logic [ACC_W-1:0] sum_abs_q;
  logic [SQ_W-1:0]  sum_sq_q;
  logic [E_W-1:0]   wce_q;
  logic [W-1:0]     wce_a_q;
  logic [W-1:0]     wce_b_q;

  // ---------------------------------------------------------------- comb
  logic             accept;
  logic             stats_clr;
  logic [E_W-1:0]   exact;
  logic [E_W-1:0]   err_in;
  logic [SQP_W-1:0] s1_err_ext;
  logic [SQP_W-1:0] sq_prod;
  logic [ACC_W:0]   abs_sum_wide;
  logic [SQ_W:0]    sq_sum_wide;
  logic [ACC_W-1:0] sum_abs_d;
  logic [SQ_W-1:0]  sum_sq_d;

  assign accept    = in_valid & in_ready_q;
  // A new window may only open from IDLE or DONE; start elsewhere is ignored.
  assign stats_clr = start & ((state_q == S_IDLE) | (state_q == S_DONE));

  always_comb begin
    exact  = {1'b0, A} + {1'b0, B};
    err_in = (exact >= O) ? (exact - O) : (O - exact);
  end

  // The square of a (W+1)-bit magnitude always fits in 2W+2 bits, so the
  // truncating multiply below is exact.
  assign s1_err_ext = {{(SQP_W - E_W){1'b0}}, s1_err_q};
  assign sq_prod    = s1_err_ext * s1_err_ext;

  // Saturating accumulators: add one bit of headroom and clamp on carry-out.
  always_comb begin
    abs_sum_wide = {1'b0, sum_abs_q} + {{(ACC_W + 1 - E_W){1'b0}}, s2_err_q};
    sq_sum_wide  = {1'b0, sum_sq_q} + {{(SQ_W + 1 - SQP_W){1'b0}}, s2_sq_q};
    sum_abs_d    = abs_sum_wide[ACC_W] ? {ACC_W{1'b1}} : abs_sum_wide[ACC_W-1:0];
    sum_sq_d     = sq_sum_wide[SQ_W]   ? {SQ_W{1'b1}}  : sq_sum_wide[SQ_W-1:0];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            n_q          <= n_samples;
            sample_cnt_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            if (n_samples == '0) begin
              // Empty window: skip RUN, the drain check completes it next edge.
              state_q    <= S_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (accept) begin
            if (sample_cnt_q != {CNT_W{1'b1}}) begin
              sample_cnt_q <= sample_cnt_q + CNT_W'(1);
            end
            // This transfer is sample N: close the input on the same edge.
            if (sample_cnt_q == n_q - CNT_W'(1)) begin
              in_ready_q <= 1'b0;
              state_q    <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          if (!s1_vld_q && !s2_vld_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_err_q  <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_vld_q  <= 1'b0;
      s2_err_q  <= '0;
      s2_sq_q   <= '0;
      s2_a_q    <= '0;
      s2_b_q    <= '0;
      err_cnt_q <= '0;
      sum_abs_q <= '0;
      sum_sq_q  <= '0;
      wce_q     <= '0;
      wce_a_q   <= '0;
      wce_b_q   <= '0;
    end else begin
      // S1: error magnitude of the transferred sample (exact sum is folded in).
      s1_vld_q <= accept;
      if (accept) begin
        s1_err_q <= err_in;
        s1_a_q   <= A;
        s1_b_q   <= B;
      end

      // S2: square the error so the accumulate edge only has adders.
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_err_q <= s1_err_q;
        s2_sq_q  <= sq_prod;
        s2_a_q   <= s1_a_q;
        s2_b_q   <= s1_b_q;
      end

      // The pipeline is always empty when a window opens, so clear and
      // accumulate never collide.
      if (stats_clr) begin
        err_cnt_q <= '0;
        sum_abs_q <= '0;
        sum_sq_q  <= '0;
        wce_q     <= '0;
        wce_a_q   <= '0;
        wce_b_q   <= '0;
      end else if (s2_vld_q) begin
        if ((s2_err_q != '0) && (err_cnt_q != {CNT_W{1'b1}})) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        sum_abs_q <= sum_abs_d;
        sum_sq_q  <= sum_sq_d;
        // Strict compare: a tie keeps the operands of the earliest sample.
        if (s2_err_q > wce_q) begin
          wce_q   <= s2_err_q;
          wce_a_q <= s2_a_q;
          wce_b_q <= s2_b_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign sum_abs_err = sum_abs_q;
  assign sum_sq_err  = sum_sq_q;
  assign wce         = wce_q;
  assign wce_A       = wce_a_q;
  assign wce_B       = wce_b_q;

endmodule

// File: tb/tb_add16u_err_monitor.sv
// Bench for add16u_err_monitor. Two instances share all stimulus: the default
// configuration and a narrow one (18-bit sum_abs_err) for saturation. A
// sample-level model (queue of in-flight errors, plain integer sums) predicts
// every output and is compared once per clock; directed windows add literal
// expectations.
module tb_add16u_err_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [16:0] O = '0;

  logic        in_ready, busy, done;
  logic [31:0] sample_cnt, err_cnt;
  logic [47:0] sum_abs_err;
  logic [63:0] sum_sq_err;
  logic [16:0] wce;
  logic [15:0] wce_A, wce_B;

  logic        in_ready2, busy2, done2;
  logic [31:0] sample_cnt2, err_cnt2;
  logic [17:0] sum_abs_err2;
  logic [63:0] sum_sq_err2;
  logic [16:0] wce2;
  logic [15:0] wce_A2, wce_B2;

  always #5 clk = ~clk;

  add16u_err_monitor dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .O(O),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .sum_abs_err(sum_abs_err), .sum_sq_err(sum_sq_err), .wce(wce),
    .wce_A(wce_A), .wce_B(wce_B)
  );

  add16u_err_monitor #(.ACC_W(18)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready2), .A(A), .B(B), .O(O),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .err_cnt(err_cnt2),
    .sum_abs_err(sum_abs_err2), .sum_sq_err(sum_sq_err2), .wce(wce2),
    .wce_A(wce_A2), .wce_B(wce_B2)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ------------------------------------------------------------ model
  typedef struct {
    int      err;
    int      a;
    int      b;
    longint  due;
  } samp_t;

  samp_t              pend[$];
  longint             cyc = 0;
  longint             m_done_at = -1;
  bit                 m_busy = 0, m_done = 0, m_ready = 0;
  longint             m_n = 0, m_cnt = 0, m_errs = 0;
  longint             m_sum = 0;
  longint unsigned    m_sq = 0;
  int                 m_wce = 0, m_wa = 0, m_wb = 0;

  function automatic longint sat(input longint v, input int bits);
    longint mx;
    mx = (longint'(1) <<< bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int abs_err(input int a, input int b, input int o);
    int ex;
    ex = a + b;
    return (ex >= o) ? ex - o : o - ex;
  endfunction

  task automatic clear_stats();
    m_cnt = 0; m_errs = 0; m_sum = 0; m_sq = 0; m_wce = 0; m_wa = 0; m_wb = 0;
  endtask

  always @(posedge clk) begin
    bit    busy_prev;
    samp_t s;
    cyc++;
    if (rst) begin
      pend.delete();
      m_busy = 0; m_done = 0; m_ready = 0; m_n = 0; m_done_at = -1;
      clear_stats();
    end else begin
      busy_prev = m_busy;
      while (pend.size() > 0 && pend[0].due == cyc) begin
        s = pend.pop_front();
        if (s.err != 0) m_errs++;
        m_sum += s.err;
        m_sq  += longint'(s.err) * longint'(s.err);
        if (s.err > m_wce) begin
          m_wce = s.err; m_wa = s.a; m_wb = s.b;
        end
      end
      if (in_valid && m_ready) begin
        m_cnt++;
        s.err = abs_err(int'(A), int'(B), int'(O));
        s.a = int'(A); s.b = int'(B); s.due = cyc + 2;
        pend.push_back(s);
        if (m_cnt == m_n) begin
          m_ready = 0;
          m_done_at = cyc + 3;   // last sample drains through two stages
        end
      end
      if (busy_prev && cyc == m_done_at) begin
        m_busy = 0; m_done = 1;
      end
      if (start && !busy_prev) begin
        clear_stats();
        m_n = longint'(n_samples);
        m_busy = 1; m_done = 0; m_ready = (n_samples != 0);
        m_done_at = (n_samples == 0) ? cyc + 1 : -1;
      end
    end
    #1;
    chk("in_ready",    in_ready,    m_ready);
    chk("busy",        busy,        m_busy);
    chk("done",        done,        m_done);
    chk("sample_cnt",  sample_cnt,  m_cnt);
    chk("err_cnt",     err_cnt,     m_errs);
    chk("sum_abs_err", sum_abs_err, sat(m_sum, 48));
    chk("sum_sq_err",  sum_sq_err,  m_sq);
    chk("wce",         wce,         m_wce);
    chk("wce_A",       wce_A,       m_wa);
    chk("wce_B",       wce_B,       m_wb);
    chk("sat_sum_abs", sum_abs_err2, sat(m_sum, 18));
    chk("sat_err_cnt", err_cnt2,    m_errs);
  end

  // ------------------------------------------------------------ drivers
  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; n_samples = n; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit v, input int a, input int b, input int o);
    in_valid = v; A = a[15:0]; B = b[15:0]; O = o[16:0];
    @(negedge clk);
  endtask

  task automatic wait_done();
    in_valid = 1'b0;
    for (int k = 0; k < 200 && !done; k++) @(negedge clk);
    chk("done_reached", done, 1);
  endtask

  task automatic drive_random();
    int a, b, ex, o, mode;
    a = $urandom_range(0, 16'hFFFF);
    b = $urandom_range(0, 16'hFFFF);
    ex = a + b;
    mode = $urandom_range(0, 3);
    case (mode)
      0: o = ex;
      1: begin
        o = ex + $urandom_range(0, 6) - 3;
        if (o < 0) o = 0;
        if (o > 17'h1FFFF) o = 17'h1FFFF;
      end
      2: o = $urandom_range(0, 17'h1FFFF);
      default: o = ex ^ (1 << $urandom_range(0, 16));
    endcase
    in_valid = ($urandom_range(0, 3) != 0);
    A = a[15:0]; B = b[15:0]; O = o[16:0];
    // Occasional start while busy must be ignored, with a different length.
    start = ($urandom_range(0, 15) == 0);
    n_samples = $urandom_range(0, 30);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy",     busy,     0);
    chk("rst_done",     done,     0);
    chk("rst_sum_abs",  sum_abs_err, 0);

    // Exact adder: no error recorded.
    do_start(4);
    for (int i = 0; i < 4; i++) feed(1, 16'h1234, 16'h0F0F, 17'h02143);
    wait_done();
    chk("t1_sample_cnt", sample_cnt, 4);
    chk("t1_err_cnt",    err_cnt,    0);
    chk("t1_sum_abs",    sum_abs_err, 0);
    chk("t1_sum_sq",     sum_sq_err, 0);
    chk("t1_wce",        wce,        0);

    // Lost carry: error of 2^16.
    do_start(1);
    feed(1, 16'hFFFF, 16'h0001, 0);
    wait_done();
    chk("t2_sum_abs", sum_abs_err, 64'd65536);
    chk("t2_sum_sq",  sum_sq_err,  64'h1_0000_0000);
    chk("t2_wce",     wce,   17'h10000);
    chk("t2_wce_A",   wce_A, 16'hFFFF);
    chk("t2_wce_B",   wce_B, 16'h0001);
    chk("t2_err_cnt", err_cnt, 1);

    // Gapped valid; the fifth sample (error 7) arrives after the window closed.
    do_start(3);
    feed(1, 100, 200, 300);
    feed(0, 1, 1, 0);
    feed(1, 5, 6, 11);
    feed(1, 7, 8, 15);
    chk("t3_ready_low", in_ready, 0);
    feed(1, 9, 9, 11);
    wait_done();
    chk("t3_sample_cnt", sample_cnt, 3);
    chk("t3_err_cnt",    err_cnt, 0);
    chk("t3_sum_abs",    sum_abs_err, 0);

    // Empty window completes two cycles after start.
    do_start(0);
    chk("t4_busy",  busy, 1);
    chk("t4_done0", done, 0);
    @(negedge clk);
    chk("t4_done1", done, 1);
    chk("t4_ready", in_ready, 0);
    chk("t4_cnt",   sample_cnt, 0);

    // Saturation of the narrow accumulator.
    do_start(4);
    for (int i = 0; i < 4; i++) feed(1, 16'hFFFF, 16'h0001, 0);
    wait_done();
    chk("t5_sat_sum",  sum_abs_err2, 262143);
    chk("t5_sat_errs", err_cnt2, 4);
    chk("t5_wide_sum", sum_abs_err, 262144);

    // Reset mid-window discards partial statistics.
    do_start(8);
    feed(1, 16'hFFFF, 16'hFFFF, 0);
    feed(1, 16'h8000, 16'h8000, 0);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_busy_after_rst", busy, 0);
    do_start(1);
    feed(1, 10, 0, 5);
    wait_done();
    chk("t6_sum_abs",    sum_abs_err, 5);
    chk("t6_sample_cnt", sample_cnt, 1);
    chk("t6_wce",        wce, 5);

    // Randomised windows.
    for (int w = 0; w < 30; w++) begin
      do_start((w % 10 == 9) ? 0 : $urandom_range(1, 24));
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (done) break;
        drive_random();
      end
      start = 1'b0; in_valid = 1'b0;
      chk("rand_window_done", done, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
